// File: rtl/cdb_pkg.sv
// rtl/cdb_pkg.sv - shared widths, source encoding and entry layout for the CDB arbiter
package cdb_pkg;

  localparam int CDB_ROB_W = 2;
  localparam int CDB_VAL_W = 3;

  typedef enum logic {
    CDB_SRC_ALU = 1'b0,
    CDB_SRC_MEM = 1'b1
  } cdb_src_e;

  typedef struct packed {
    logic [CDB_ROB_W-1:0] rob_idx;
    logic [CDB_VAL_W-1:0] val;
  } cdb_entry_t;

endpackage

// File: rtl/cdb_fifo.sv
// rtl/cdb_fifo.sv - per-source completion buffer, DEPTH entries (power of two)
module cdb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 5,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin CDB arbiter between ALU and memory completions
// Optional conflict counter built when CDB_PERF_CNT_EN is defined.
import cdb_pkg::*;

module cdb_arbiter #(
  parameter int DEPTH = 2,
  parameter int ROB_W = CDB_ROB_W,
  parameter int VAL_W = CDB_VAL_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             alu_valid,
  input  logic [ROB_W-1:0] alu_rob_idx,
  input  logic [VAL_W-1:0] alu_val,
  output logic             alu_ready,
  input  logic             mem_valid,
  input  logic [ROB_W-1:0] mem_rob_idx,
  input  logic [VAL_W-1:0] mem_val,
  output logic             mem_ready,
  output logic             cdb_valid,
  output logic [ROB_W-1:0] cdb_rob_idx,
  output logic [VAL_W-1:0] cdb_val,
  output logic             cdb_src,
  output logic             idle,
  output logic [5:0]       conflict_cnt
);

  localparam int E_W   = ROB_W + VAL_W;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [E_W-1:0]   alu_head, mem_head;
  logic [CNT_W-1:0] alu_count, mem_count;
  logic             alu_full, mem_full;
  logic             alu_empty, mem_empty;
  logic             grant_alu, grant_mem, both_pending;
  cdb_src_e         last_grant;

  assign alu_ready = !alu_full;
  assign mem_ready = !mem_full;

  // Ties go to whichever source did not win last time.
  assign both_pending = !alu_empty && !mem_empty;
  assign grant_alu    = !alu_empty && (mem_empty || last_grant == CDB_SRC_MEM);
  assign grant_mem    = !mem_empty && !grant_alu;

  assign idle = (alu_count == '0) && (mem_count == '0) && !cdb_valid;

  cdb_fifo #(.DEPTH(DEPTH), .WIDTH(E_W)) u_alu_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (alu_valid && alu_ready),
    .pop       (grant_alu),
    .push_data ({alu_rob_idx, alu_val}),
    .head      (alu_head),
    .count     (alu_count),
    .full      (alu_full),
    .empty     (alu_empty)
  );

  cdb_fifo #(.DEPTH(DEPTH), .WIDTH(E_W)) u_mem_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (mem_valid && mem_ready),
    .pop       (grant_mem),
    .push_data ({mem_rob_idx, mem_val}),
    .head      (mem_head),
    .count     (mem_count),
    .full      (mem_full),
    .empty     (mem_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      cdb_valid   <= 1'b0;
      cdb_rob_idx <= '0;
      cdb_val     <= '0;
      cdb_src     <= CDB_SRC_ALU;
      last_grant  <= CDB_SRC_MEM;
    end else if (flush) begin
      cdb_valid <= 1'b0;
    end else if (grant_alu) begin
      cdb_valid                <= 1'b1;
      {cdb_rob_idx, cdb_val}   <= alu_head;
      cdb_src                  <= CDB_SRC_ALU;
      last_grant               <= CDB_SRC_ALU;
    end else if (grant_mem) begin
      cdb_valid                <= 1'b1;
      {cdb_rob_idx, cdb_val}   <= mem_head;
      cdb_src                  <= CDB_SRC_MEM;
      last_grant               <= CDB_SRC_MEM;
    end else begin
      cdb_valid <= 1'b0;
    end
  end

`ifdef CDB_PERF_CNT_EN
  logic [5:0] conflict_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      conflict_q <= '0;
    end else if (both_pending && conflict_q != 6'd63) begin
      conflict_q <= conflict_q + 6'd1;
    end
  end

  assign conflict_cnt = conflict_q;
`else
  logic unused_both;
  assign unused_both  = both_pending;
  assign conflict_cnt = '0;
`endif

endmodule
